disp_pixel_reader: RTL and testbench
====================================

# disp_pixel_reader

Display-side consumer of the 125→25 MHz pixel FIFO fed by the memory read path. Generates VGA raster timing, issues the display request that starts frame-buffer readout, pops one FIFO word per active pixel, and drives registered sync, data-enable and 12-bit RGB444 to the video output stage. Underflow is masked to black and reported on a sticky flag.

## Interface
Parameters:
- DATA_WIDTH, 12, pixel width (RGB444: [11:8] R, [7:4] G, [3:0] B)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines
- SYNC_POL, 0, active level of o_hsync/o_vsync

Ports:
- i_clk  in  1  pixel clock (25 MHz)
- i_rstn  in  1  synchronous, active-low reset
- o_req  out  1  display request to memory read side; high while armed or running
- o_rd  out  1  FIFO read enable
- i_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after o_rd
- i_empty  in  1  FIFO empty flag
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  data enable (active pixel)
- o_rgb  out  DATA_WIDTH  pixel data; 0 when o_de low or pixel underflowed
- o_underflow  out  1  sticky: a pixel slot found the FIFO empty while running

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), v_cnt 0..V_TOTAL-1; h wraps every cycle at H_TOTAL-1, v increments on h wrap and wraps at V_TOTAL-1. Both free-run from reset.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync asserted (= SYNC_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v_cnt; otherwise !SYNC_POL.
- FSM:
  - S_IDLE: entered on reset, o_req=0; next cycle → S_ARM.
  - S_ARM: o_req=1, o_rd=0. Transition to S_RUN when h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1 && !i_empty (first pixel of next frame is fetched from FIFO).
  - S_RUN: o_req=1; o_rd = active && !i_empty (combinational from registered counters/state and i_empty). Stays in S_RUN until reset.
- Underflow: in S_RUN, active && i_empty → no pop, that slot outputs 0, o_underflow set. Pixel stream slips; no realignment. Cleared only by reset.
- Never asserts o_rd outside active slots or when i_empty=1.

## Timing
- Reset values: o_req=0, o_rd=0, o_hsync=o_vsync=!SYNC_POL, o_de=0, o_rgb=0, o_underflow=0, h_cnt=v_cnt=0, state S_IDLE.
- Pipeline: stage 1 registers active/hsync/vsync and rd_d = o_rd; stage 2 registers o_de, o_hsync, o_vsync, and o_rgb = rd_d ? i_rdata : 0. Outputs lag counters by exactly 2 cycles; o_rgb aligned with o_de.
- o_underflow registered, rises 1 cycle after the empty active slot.
- FIFO rdata read one cycle after o_rd; no other read latency supported.
- Reset mid-frame: all outputs return to reset values the next cycle; counters restart at 0; first popped pixel is again at frame start after S_ARM.

## Structure
- Package disp_pkg: timing parameter defaults, H_TOTAL/V_TOTAL localparams, FSM state enum (S_IDLE, S_ARM, S_RUN).
- Sub-module disp_timing: h/v counters, active/hsync/vsync decode, end-of-frame strobe. disp_pixel_reader holds FSM, FIFO read, output pipeline, underflow flag.

## Test plan
- Reset release, FIFO held empty 2 frames → o_req=1 from cycle 2, o_rd never asserted, o_de toggles with 640 pixels/line, hsync low 96 cycles per 800-cycle line, vsync low 2 lines per 525.
- FIFO model prefilled with incrementing 12-bit counter before first frame end → first o_de pixel of frame shows 0x000, line 0 ends 0x27F, exactly 307200 pops per frame, o_underflow=0.
- o_de/o_rgb alignment: check o_rgb equals word popped 2 cycles after its o_rd edge and is 0 whenever o_de=0.
- Force i_empty=1 for 5 active cycles mid-line → 5 black pixels, no pops during them, o_underflow rises and stays 1 to frame end and beyond.
- Assert i_rstn=0 for 1 cycle at v_cnt=200 → next cycle all outputs at reset values, o_req low 1 cycle then high, pops resume only at following frame start.
- Small-parameter run (H_ACTIVE=4, fronts/syncs/backs=1, V_ACTIVE=3) → counter wrap, sync windows and 12 pops/frame match exactly.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared timing defaults, FSM state type and window helper for the display pixel reader.
package disp_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 12;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } disp_state_e;

  // True when lo <= cnt < hi.
  function automatic logic in_window(input logic [31:0] cnt, input int unsigned lo,
                                     input int unsigned hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/disp_timing.sv
// Free-running raster counters with active/sync decode and an end-of-frame strobe.
module disp_timing
  import disp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_active,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_eof
);

  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;
  logic [31:0]   h_ext, v_ext;

  // Counter wrap detection and next-count computation.
  always_comb begin
    h_last  = (h_cnt_q == HW'(HTot - 1));
    v_last  = (v_cnt_q == VW'(VTot - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Raster counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode of the current raster position.
  always_comb begin
    h_ext    = 32'(h_cnt_q);
    v_ext    = 32'(v_cnt_q);
    o_active = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    o_hsync  = in_window(h_ext, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL
                                                                          : ~SYNC_POL;
    o_vsync  = in_window(v_ext, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL
                                                                          : ~SYNC_POL;
    o_eof    = h_last && v_last;
  end

endmodule

// File: rtl/disp_pixel_reader.sv
// Display-side FIFO consumer: arms a frame request, pops one word per active pixel and
// drives a two-stage registered video output with underflow masking.
module disp_pixel_reader
  import disp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          SYNC_POL   = DEF_SYNC_POL
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_req,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_empty,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_rgb,
  output logic                  o_underflow
);

  logic tim_active, tim_hsync, tim_vsync, tim_eof;

  disp_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .o_active (tim_active),
    .o_hsync  (tim_hsync),
    .o_vsync  (tim_vsync),
    .o_eof    (tim_eof)
  );

  disp_state_e           state_q, state_d;
  logic                  slot_underflow;

  // Stage 1: decode and read strobe, aligned with the FIFO data return.
  logic                  act_q, act_d;
  logic                  hs1_q, hs1_d;
  logic                  vs1_q, vs1_d;
  logic                  rd_q, rd_d;
  // Stage 2: output registers.
  logic                  de_q, de_d;
  logic                  hs2_q, hs2_d;
  logic                  vs2_q, vs2_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic                  uf_q, uf_d;

  // FSM next state and FIFO read strobe; a run only begins on a frame boundary with data ready.
  always_comb begin
    state_d        = state_q;
    o_req          = 1'b0;
    o_rd           = 1'b0;
    slot_underflow = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_ARM;
      S_ARM: begin
        o_req = 1'b1;
        if (tim_eof && !i_empty) state_d = S_RUN;
      end
      S_RUN: begin
        o_req          = 1'b1;
        o_rd           = tim_active && !i_empty;
        slot_underflow = tim_active && i_empty;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output pipeline next-state; data is taken only for slots that actually popped.
  always_comb begin
    act_d = tim_active;
    hs1_d = tim_hsync;
    vs1_d = tim_vsync;
    rd_d  = o_rd;
    de_d  = act_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    rgb_d = rd_q ? i_rdata : '0;
    uf_d  = uf_q | slot_underflow;
  end

  // State, pipeline and sticky underflow registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      act_q   <= 1'b0;
      hs1_q   <= ~SYNC_POL;
      vs1_q   <= ~SYNC_POL;
      rd_q    <= 1'b0;
      de_q    <= 1'b0;
      hs2_q   <= ~SYNC_POL;
      vs2_q   <= ~SYNC_POL;
      rgb_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      rd_q    <= rd_d;
      de_q    <= de_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
    end
  end

  assign o_hsync     = hs2_q;
  assign o_vsync     = vs2_q;
  assign o_de        = de_q;
  assign o_rgb       = rgb_q;
  assign o_underflow = uf_q;

endmodule

// File: tb/tb_disp_pixel_reader.sv
// Bench for disp_pixel_reader: small-raster instance checked every cycle against a
// time-indexed raster model, plus a default-parameter instance checked on line statistics.
module tb_disp_pixel_reader;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam bit POL = 1'b0;

  logic        clk;
  logic        rstn, rstn_b;
  logic        fill_en, force_e;
  logic        req, rd, empty, hs, vs, de, uf;
  logic [11:0] rdata, rgb;
  logic        req_b, rd_b, hs_b, vs_b, de_b, uf_b;
  logic [11:0] rgb_b;
  logic        empty_b;
  logic [11:0] rdata_b;

  int n_chk, n_pass;

  assign empty   = !fill_en || force_e;
  assign empty_b = 1'b1;
  assign rdata_b = 12'h000;

  disp_pixel_reader #(
    .DATA_WIDTH (12),
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .SYNC_POL   (POL)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .o_req       (req),
    .o_rd        (rd),
    .i_rdata     (rdata),
    .i_empty     (empty),
    .o_hsync     (hs),
    .o_vsync     (vs),
    .o_de        (de),
    .o_rgb       (rgb),
    .o_underflow (uf)
  );

  disp_pixel_reader dut_b (
    .i_clk       (clk),
    .i_rstn      (rstn_b),
    .o_req       (req_b),
    .o_rd        (rd_b),
    .i_rdata     (rdata_b),
    .i_empty     (empty_b),
    .o_hsync     (hs_b),
    .o_vsync     (vs_b),
    .o_de        (de_b),
    .o_rgb       (rgb_b),
    .o_underflow (uf_b)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Per-cycle model: expected outputs derived from cycles elapsed since the last reset edge.
  initial begin : cmp
    int          mt, h, v;
    bit          running, uf_m, act, hs_c, vs_c, exp_rd;
    int unsigned pop_idx;
    logic        prev_rstn;
    logic        ha_h [2];
    logic        hs_h [2];
    logic        vs_h [2];
    logic        rd_h [2];
    logic [11:0] wd_h [2];
    mt = 0; running = 0; uf_m = 0; pop_idx = 0; prev_rstn = 1'b0;
    forever begin
      @(negedge clk);
      if (!prev_rstn) begin
        mt = 0; running = 0; uf_m = 0;
        for (int i = 0; i < 2; i++) begin
          ha_h[i] = 1'b0; hs_h[i] = ~POL; vs_h[i] = ~POL; rd_h[i] = 1'b0; wd_h[i] = '0;
        end
      end else begin
        mt++;
      end
      h      = mt % HT;
      v      = (mt / HT) % VT;
      act    = (h < HA) && (v < VA);
      hs_c   = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
      vs_c   = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
      exp_rd = running && act && !empty;
      chk("o_req", 32'(req), 32'(mt >= 1));
      chk("o_rd", 32'(rd), 32'(exp_rd));
      chk("o_de", 32'(de), 32'(ha_h[1]));
      chk("o_hsync", 32'(hs), 32'(hs_h[1]));
      chk("o_vsync", 32'(vs), 32'(vs_h[1]));
      chk("o_rgb", 32'(rgb), rd_h[1] ? 32'(wd_h[1]) : 32'd0);
      chk("o_underflow", 32'(uf), 32'(uf_m));
      ha_h[1] = ha_h[0]; hs_h[1] = hs_h[0]; vs_h[1] = vs_h[0];
      rd_h[1] = rd_h[0]; wd_h[1] = wd_h[0];
      ha_h[0] = act; hs_h[0] = hs_c; vs_h[0] = vs_c; rd_h[0] = exp_rd;
      wd_h[0] = 12'(pop_idx);
      if (exp_rd) pop_idx++;
      if (running && act && empty) uf_m = 1'b1;
      if (!running && mt >= 1 && h == HT - 1 && v == VT - 1 && !empty) running = 1'b1;
      prev_rstn = rstn;
    end
  end

  // Driver-side samples and FIFO responder state.
  logic        rd_seen, s_req, s_de, s_hs, s_vs, s_uf;
  logic [11:0] s_rgb;
  int          cyc, s_cyc, stim_cnt;
  bit          b_on;
  int          b_cyc, b_de, b_hs, b_vs, b_rd, b_nz;

  // Sample this cycle's outputs, then answer a pop with the next incrementing word.
  task automatic tick();
    @(negedge clk);
    rd_seen = rd; s_req = req; s_de = de; s_hs = hs; s_vs = vs; s_uf = uf; s_rgb = rgb;
    s_cyc   = cyc;
    if (b_on && b_cyc < 1600) begin
      b_de += int'(de_b); b_hs += int'(!hs_b); b_vs += int'(!vs_b);
      b_rd += int'(rd_b); b_nz += int'(rgb_b != 12'h000);
      b_cyc++;
    end
    @(posedge clk);
    #1;
    if (rd_seen) begin
      rdata = 12'(stim_cnt);
      stim_cnt++;
    end
    cyc++;
  endtask

  initial begin : drv
    int  c_de, c_hs, c_vs, c_rd, first, r1;
    bit  found;
    n_chk = 0; n_pass = 0; cyc = 0; stim_cnt = 0;
    b_on = 0; b_cyc = 0; b_de = 0; b_hs = 0; b_vs = 0; b_rd = 0; b_nz = 0;
    rstn = 1'b0; rstn_b = 1'b0; fill_en = 1'b0; force_e = 1'b0; rdata = '0;
    repeat (3) tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_rd", 32'(rd_seen), 32'd0);
    chk("rst_hsync", 32'(s_hs), 32'd1);
    chk("rst_vsync", 32'(s_vs), 32'd1);
    chk("rst_de", 32'(s_de), 32'd0);
    chk("rst_rgb", 32'(s_rgb), 32'd0);
    chk("rst_uf", 32'(s_uf), 32'd0);
    rstn = 1'b1; rstn_b = 1'b1; b_on = 1;

    // FIFO empty: one full frame window of raster statistics, no pops.
    repeat (5) tick();
    c_de = 0; c_hs = 0; c_vs = 0; c_rd = 0;
    repeat (HT * VT) begin
      tick();
      c_de += int'(s_de); c_hs += int'(!s_hs); c_vs += int'(!s_vs); c_rd += int'(rd_seen);
    end
    chk("empty_de_per_frame", 32'(c_de), 32'd32);
    chk("empty_hs_per_frame", 32'(c_hs), 32'd24);
    chk("empty_vs_per_frame", 32'(c_vs), 32'd30);
    chk("empty_pops", 32'(c_rd), 32'd0);
    chk("armed_req", 32'(s_req), 32'd1);
    repeat (115) tick();

    // FIFO filled: first pop lands at a frame start.
    fill_en = 1'b1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (rd_seen) found = 1;
    end
    chk("first_pop_seen", 32'(found), 32'd1);
    c_rd = 1;
    for (int k = 1; k < HT * VT; k++) begin
      tick();
      c_rd += int'(rd_seen);
      if (k == 2) begin
        chk("first_pix_de", 32'(s_de), 32'd1);
        chk("first_pix_rgb", 32'(s_rgb), 32'h000);
      end
      if (k == 9) chk("line0_last_rgb", 32'(s_rgb), 32'h007);
      if (k == 10) chk("line0_after_de", 32'(s_de), 32'd0);
    end
    chk("pops_per_frame", 32'(c_rd), 32'd32);
    chk("no_underflow", 32'(s_uf), 32'd0);

    // Five forced-empty slots mid-line 0 (h = 3..7).
    repeat (3) tick();
    force_e = 1'b1;
    c_rd = 0;
    repeat (5) begin
      tick();
      c_rd += int'(rd_seen);
    end
    force_e = 1'b0;
    chk("forced_pops", 32'(c_rd), 32'd0);
    tick();
    chk("black_pix_de", 32'(s_de), 32'd1);
    chk("black_pix_rgb", 32'(s_rgb), 32'd0);
    tick();
    chk("uf_rise", 32'(s_uf), 32'd1);
    repeat (150) tick();
    chk("uf_sticky", 32'(s_uf), 32'd1);

    // One-cycle mid-frame reset.
    repeat (40) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    r1 = s_cyc;
    chk("mrst_req", 32'(s_req), 32'd0);
    chk("mrst_rd", 32'(rd_seen), 32'd0);
    chk("mrst_de", 32'(s_de), 32'd0);
    chk("mrst_rgb", 32'(s_rgb), 32'd0);
    chk("mrst_uf", 32'(s_uf), 32'd0);
    chk("mrst_hsync", 32'(s_hs), 32'd1);
    chk("mrst_vsync", 32'(s_vs), 32'd1);
    tick();
    chk("mrst_req_back", 32'(s_req), 32'd1);
    found = 0; first = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (rd_seen) begin
        found = 1;
        first = s_cyc;
      end
    end
    chk("mrst_pop_seen", 32'(found), 32'd1);
    chk("mrst_pop_delay", 32'(first - r1), 32'd120);
    repeat (20) tick();

    // Default-parameter instance: first two lines with FIFO held empty.
    for (int i = 0; i < 2000 && b_cyc < 1600; i++) tick();
    chk("def_de_2lines", 32'(b_de), 32'd1280);
    chk("def_hs_2lines", 32'(b_hs), 32'd192);
    chk("def_vs_2lines", 32'(b_vs), 32'd0);
    chk("def_pops", 32'(b_rd), 32'd0);
    chk("def_rgb_nonzero", 32'(b_nz), 32'd0);
    chk("def_req", 32'(req_b), 32'd1);
    chk("def_uf", 32'(uf_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
